// File: rtl/fft_pair_feeder_if.sv
// Sample-in / butterfly-pair-out bundle between the sample source, the feeder and the FFT PE.
// master: the feeder side; slave: the source/PE side.
interface fft_pair_feeder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_PTS  = 16
);
    localparam int unsigned PW = $clog2(N_PTS / 2);

    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [PW-1:0]     power;
    logic              ab_valid;
    logic              frame_done;

    modport master (
        input  data_in, data_valid,
        output in_ready, a, b, power, ab_valid, frame_done
    );

    modport slave (
        output data_in, data_valid,
        input  in_ready, a, b, power, ab_valid, frame_done
    );
endinterface

// File: rtl/fft_pair_feeder.sv
// Buffers one N_PTS-sample frame, then issues the radix-2 stage-1 pairs (x[k], x[k+N/2]).
// Define FFT_FEEDER_BITREV_EN to store samples at bit-reversed write addresses.
module fft_pair_feeder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_PTS  = 16
) (
    input logic               clk,
    input logic               rst,
    fft_pair_feeder_if.master bus
);
    localparam int unsigned N_PAIRS = N_PTS / 2;
    localparam int unsigned AW      = $clog2(N_PTS);
    localparam int unsigned PW      = $clog2(N_PAIRS);

    typedef enum logic [1:0] {StLoad, StSend, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
    logic [PW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_lo, rd_hi;
    logic              accept;
    logic [DATA_W-1:0] mem_q [N_PTS];

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]     power_q, power_d;
    logic              ab_valid_q, ab_valid_d;
    logic              frame_done_q, frame_done_d;

    assign accept = (state_q == StLoad) && bus.data_valid;

    // Lower half holds x[k], upper half x[k+N/2]; the MSB selects the half.
    assign rd_lo = {1'b0, rd_cnt_q};
    assign rd_hi = {1'b1, rd_cnt_q};

`ifdef FFT_FEEDER_BITREV_EN
    always_comb begin
        wr_addr = '0;
        for (int i = 0; i < int'(AW); i++) begin
            wr_addr[i] = wr_cnt_q[int'(AW) - 1 - i];
        end
    end
`else
    assign wr_addr = wr_cnt_q;
`endif

    // State register, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StLoad;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            power_q      <= '0;
            ab_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            power_q      <= power_d;
            ab_valid_q   <= ab_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_PTS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_addr] <= bus.data_in;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (wr_cnt_q == AW'(N_PTS - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = StSend;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            StSend: begin
                if (rd_cnt_q == PW'(N_PAIRS - 1)) begin
                    rd_cnt_d = '0;
                    state_d  = StDone;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StLoad;
            default: state_d = StLoad;
        endcase
    end

    // Output next values; everything outside SEND/DONE drives zeros so the PE never sees stale data.
    always_comb begin
        a_d          = '0;
        b_d          = '0;
        power_d      = '0;
        ab_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_q)
            StSend: begin
                a_d        = mem_q[rd_lo];
                b_d        = mem_q[rd_hi];
                power_d    = rd_cnt_q;
                ab_valid_d = 1'b1;
            end
            StDone:  frame_done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready   = (state_q == StLoad);
    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.power      = power_q;
    assign bus.ab_valid   = ab_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_pair_feeder.sv
// Self-checking bench for fft_pair_feeder: randomized frames against a frame-level pair model.
module tb_fft_pair_feeder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_pair_feeder_if #(.DATA_W(32), .N_PTS(16)) bus ();

    fft_pair_feeder #(.DATA_W(32), .N_PTS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] frm [16];
    int          early, not_ready, stray;
    logic [31:0] cap_a [8];
    logic [31:0] cap_b [8];
    logic [2:0]  cap_p [8];
    logic        cap_v [8];
    logic        lat_ab, lat_rdy, fd_fd, fd_ab, fd_rdy;
    logic [31:0] fd_a, fd_b;
    logic [2:0]  fd_p;

    // Reference: which input sample index lands in butterfly slot j.
    function automatic int src_idx(int j);
        int r;
        r = j;
`ifdef FFT_FEEDER_BITREV_EN
        r = 0;
        for (int bt = 0; bt < 4; bt++) if (((j >> bt) & 1) != 0) r += (8 >> bt);
`endif
        return r;
    endfunction

    function automatic logic [31:0] exp_a(int k);
        return frm[src_idx(k)];
    endfunction

    function automatic logic [31:0] exp_b(int k);
        return frm[src_idx(k + 8)];
    endfunction

    task automatic gen_random();
        for (int i = 0; i < 16; i++) frm[i] = $urandom;
    endtask

    // Drives n samples of frm from the current negedge; ends at the negedge after the last accept.
    task automatic feed(input int n, input bit toggle, input bit hold_junk);
        int i;
        bit gap;
        i = 0;
        gap = 1'b0;
        early = 0;
        not_ready = 0;
        while (i < n) begin
            if (gap) begin
                bus.data_valid = 1'b0;
                bus.data_in    = $urandom;
            end else begin
                if (bus.in_ready !== 1'b1) not_ready++;
                bus.data_valid = 1'b1;
                bus.data_in    = frm[i];
                i++;
            end
            gap = toggle && !gap;
            @(negedge clk);
            if (bus.ab_valid !== 1'b0 || bus.frame_done !== 1'b0) early++;
        end
        bus.data_valid = hold_junk;
        bus.data_in    = 32'hDEAD_BEEF;
    endtask

    // Records the 8 pair cycles and the following frame_done cycle.
    task automatic capture();
        lat_ab  = bus.ab_valid;
        lat_rdy = bus.in_ready;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cap_v[k] = bus.ab_valid;
            cap_a[k] = bus.a;
            cap_b[k] = bus.b;
            cap_p[k] = bus.power;
        end
        @(negedge clk);
        fd_fd  = bus.frame_done;
        fd_ab  = bus.ab_valid;
        fd_a   = bus.a;
        fd_b   = bus.b;
        fd_p   = bus.power;
        fd_rdy = bus.in_ready;
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.data_valid = 1'b0;
        bus.data_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.ab_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ab_valid=%b frame_done=%b want 0 0",
                     bus.ab_valid, bus.frame_done);
        end
        n_cmp++;
        if ({bus.a, bus.b, bus.power} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_data: got a=%h b=%h power=%0d want 0", bus.a, bus.b, bus.power);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) frm[i] = {16'(i), 16'(100 + i)};
        feed(16, 1'b0, 1'b0);
        capture();
        n_cmp++;
        if (early !== 0 || not_ready !== 0 || lat_ab !== 1'b0 || lat_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_load: got early=%0d not_ready=%0d lat_ab=%b lat_rdy=%b want 0 0 0 0",
                     early, not_ready, lat_ab, lat_rdy);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({cap_v[k], cap_a[k], cap_b[k], cap_p[k]} !== {1'b1, exp_a(k), exp_b(k), 3'(k)}) begin
                n_bad++;
                $display("FAIL basic_pair%0d: got v=%b a=%h b=%h p=%0d want v=1 a=%h b=%h p=%0d",
                         k, cap_v[k], cap_a[k], cap_b[k], cap_p[k], exp_a(k), exp_b(k), k);
            end
        end
        n_cmp++;
        if ({fd_fd, fd_ab, fd_a, fd_b, fd_p, fd_rdy} !== {1'b1, 1'b0, 64'd0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL basic_done: got fd=%b v=%b a=%h b=%h p=%0d rdy=%b want 1 0 0 0 0 1",
                     fd_fd, fd_ab, fd_a, fd_b, fd_p, fd_rdy);
        end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 16; i++) frm[i] = {16'(i), 16'(100 + i)};
        feed(16, 1'b1, 1'b0);
        capture();
        n_cmp++;
        if (early !== 0 || not_ready !== 0 || lat_ab !== 1'b0 || lat_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL toggle_load: got early=%0d not_ready=%0d lat_ab=%b lat_rdy=%b want 0 0 0 0",
                     early, not_ready, lat_ab, lat_rdy);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({cap_v[k], cap_a[k], cap_b[k], cap_p[k]} !== {1'b1, exp_a(k), exp_b(k), 3'(k)}) begin
                n_bad++;
                $display("FAIL toggle_pair%0d: got v=%b a=%h b=%h p=%0d want v=1 a=%h b=%h p=%0d",
                         k, cap_v[k], cap_a[k], cap_b[k], cap_p[k], exp_a(k), exp_b(k), k);
            end
        end
        n_cmp++;
        if ({fd_fd, fd_ab, fd_a, fd_b, fd_p, fd_rdy} !== {1'b1, 1'b0, 64'd0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL toggle_done: got fd=%b v=%b a=%h b=%h p=%0d rdy=%b want 1 0 0 0 0 1",
                     fd_fd, fd_ab, fd_a, fd_b, fd_p, fd_rdy);
        end
    endtask

    // Junk held valid through SEND/DONE, then frames follow back to back at the minimum period.
    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            gen_random();
            feed(16, 1'b0, 1'b1);
            capture();
            n_cmp++;
            if (early !== 0 || not_ready !== 0 || lat_ab !== 1'b0 || lat_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b%0d_load: got early=%0d not_ready=%0d lat_ab=%b lat_rdy=%b want 0",
                         f, early, not_ready, lat_ab, lat_rdy);
            end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if ({cap_v[k], cap_a[k], cap_b[k], cap_p[k]} !==
                    {1'b1, exp_a(k), exp_b(k), 3'(k)}) begin
                    n_bad++;
                    $display("FAIL b2b%0d_pair%0d: got v=%b a=%h b=%h p=%0d want v=1 a=%h b=%h p=%0d",
                             f, k, cap_v[k], cap_a[k], cap_b[k], cap_p[k], exp_a(k), exp_b(k), k);
                end
            end
            n_cmp++;
            if ({fd_fd, fd_ab, fd_a, fd_b, fd_p, fd_rdy} !== {1'b1, 1'b0, 64'd0, 3'd0, 1'b1}) begin
                n_bad++;
                $display("FAIL b2b%0d_done: got fd=%b v=%b a=%h b=%h p=%0d rdy=%b want 1 0 0 0 0 1",
                         f, fd_fd, fd_ab, fd_a, fd_b, fd_p, fd_rdy);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        gen_random();
        feed(10, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        gen_random();
        feed(16, 1'b0, 1'b0);
        capture();
        n_cmp++;
        if (early !== 0 || not_ready !== 0 || lat_ab !== 1'b0 || lat_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstload_load: got early=%0d not_ready=%0d lat_ab=%b lat_rdy=%b want 0 0 0 0",
                     early, not_ready, lat_ab, lat_rdy);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({cap_v[k], cap_a[k], cap_b[k], cap_p[k]} !== {1'b1, exp_a(k), exp_b(k), 3'(k)}) begin
                n_bad++;
                $display("FAIL rstload_pair%0d: got v=%b a=%h b=%h p=%0d want v=1 a=%h b=%h p=%0d",
                         k, cap_v[k], cap_a[k], cap_b[k], cap_p[k], exp_a(k), exp_b(k), k);
            end
        end
        n_cmp++;
        if ({fd_fd, fd_ab, fd_rdy} !== 3'b101) begin
            n_bad++;
            $display("FAIL rstload_done: got fd=%b v=%b rdy=%b want 1 0 1", fd_fd, fd_ab, fd_rdy);
        end
    endtask

    task automatic test_reset_mid_send();
        gen_random();
        feed(16, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.ab_valid !== 1'b1 || bus.power !== 3'd3 || bus.a !== exp_a(3)) begin
            n_bad++;
            $display("FAIL rstsend_pre: got v=%b p=%0d a=%h want v=1 p=3 a=%h",
                     bus.ab_valid, bus.power, bus.a, exp_a(3));
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.ab_valid, bus.a, bus.b, bus.power, bus.in_ready, bus.frame_done} !==
            {1'b0, 64'd0, 3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rstsend_now: got v=%b a=%h b=%h p=%0d rdy=%b fd=%b want 0 0 0 0 1 0",
                     bus.ab_valid, bus.a, bus.b, bus.power, bus.in_ready, bus.frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.ab_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.in_ready !== 1'b1) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++; $display("FAIL rstsend_quiet: got %0d active cycles want 0", stray);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 16; i++) frm[i] = 32'(i);
        feed(16, ($urandom_range(0, 1) == 1), 1'b0);
        capture();
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({cap_v[k], cap_a[k], cap_b[k], cap_p[k]} !== {1'b1, exp_a(k), exp_b(k), 3'(k)}) begin
                n_bad++;
                $display("FAIL ramp_pair%0d: got v=%b a=%h b=%h p=%0d want v=1 a=%h b=%h p=%0d",
                         k, cap_v[k], cap_a[k], cap_b[k], cap_p[k], exp_a(k), exp_b(k), k);
            end
        end
        n_cmp++;
        if ({fd_fd, fd_ab, fd_rdy} !== 3'b101) begin
            n_bad++;
            $display("FAIL ramp_done: got fd=%b v=%b rdy=%b want 1 0 1", fd_fd, fd_ab, fd_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_send();
        test_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
